// File: rtl/program_loader.sv
// program_loader: assembles UART bytes into 32-bit words and writes them to program memory.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   i_load_start             pulse that starts a load at address 0
//   i_rx_data, i_rx_done     received byte and its one-cycle strobe
//   o_program_memory_write   one-cycle write enable
//   o_instruction_write      word being written (held after the write)
//   o_address_write          address being written (held after the write)
//   o_busy                   load in progress
//   o_load_done              halt word has been written
//   o_error                  address space exhausted before a halt word
module program_loader #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [7:0]  ADDR_INC  = 8'd1,
    parameter logic [7:0]  ADDR_MAX  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_done,
    output logic        o_program_memory_write,
    output logic [31:0] o_instruction_write,
    output logic [7:0]  o_address_write,
    output logic        o_busy,
    output logic        o_load_done,
    output logic        o_error
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
    localparam logic [7:0] LAST_OK = ADDR_MAX - ADDR_INC;
    state_t      r_state;
    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_addr;
    logic [31:0] w_next_word;
    assign w_next_word = {r_word[23:0], i_rx_data};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                <= IDLE;
            r_word                 <= '0;
            r_byte_cnt             <= '0;
            r_addr                 <= '0;
            o_program_memory_write <= 1'b0;
            o_instruction_write    <= '0;
            o_address_write        <= '0;
            o_busy                 <= 1'b0;
            o_load_done            <= 1'b0;
            o_error                <= 1'b0;
        end else begin
            o_program_memory_write <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (i_load_start) begin
                        r_state     <= RECV;
                        r_addr      <= '0;
                        r_byte_cnt  <= '0;
                        r_word      <= '0;
                        o_load_done <= 1'b0;
                        o_error     <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                RECV: begin
                    if (i_rx_done) begin
                        r_word     <= w_next_word;
                        // 2-bit counter wraps to 0 on the 4th byte
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // write is issued the cycle after the 4th byte
                            r_state                <= WRITE;
                            o_program_memory_write <= 1'b1;
                            o_instruction_write    <= w_next_word;
                            o_address_write        <= r_addr;
                        end
                    end
                end
                WRITE: begin
                    if (r_word == HALT_WORD) begin
                        r_state     <= DONE;
                        o_load_done <= 1'b1;
                        o_busy      <= 1'b0;
                    end else if (r_addr > LAST_OK) begin
                        r_state <= ERROR;
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        r_state <= RECV;
                        r_addr  <= r_addr + ADDR_INC;
                        // a byte landing in this cycle starts the next word
                        if (i_rx_done) begin
                            r_word     <= {24'b0, i_rx_data};
                            r_byte_cnt <= 2'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of the fetch stage's instruction-memory write port.
- Assembles the byte stream from the debug UART receiver into 32-bit instruction words and writes them to consecutive program-memory addresses.
- Terminates on a halt word or on address-space overflow.
- Drives the fetch stage's program-memory write-enable, write-data and write-address inputs.

Parameters:
- HALT_WORD, 32'hFFFF_FFFF, instruction word that ends the load; it is itself written to memory.
- ADDR_INC, 1, address increment per written word.
- ADDR_MAX, 8'hFF, last legal write address.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_load_start  in  1  single-cycle pulse; starts a load from address 0.
- i_rx_data  in  8  received byte; valid only when i_rx_done=1.
- i_rx_done  in  1  single-cycle strobe, one per received byte.
- o_program_memory_write  out  1  single-cycle memory write enable.
- o_instruction_write  out  32  word to write; valid with the write enable.
- o_address_write  out  8  write address; valid with the write enable.
- o_busy  out  1  high while a load is in progress (RECV or WRITE).
- o_load_done  out  1  level; high after the halt word is written.
- o_error  out  1  level; high after overflow.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) sets state=IDLE, word=0, byte_cnt=0, addr=0, and drives every output to 0.
- Reset mid-load aborts the load immediately. No write is issued in the reset cycle or the following cycle.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - o_busy=0.
  - i_load_start -> RECV; addr=0, byte_cnt=0, word=0, o_load_done=0, o_error=0.
  - i_rx_done in IDLE is ignored.
- RECV:
  - o_busy=1.
  - On i_rx_done: word <= {word[23:0], i_rx_data} (first byte received = bits 31:24, big-endian); byte_cnt++.
  - When the 4th byte is accepted: byte_cnt -> 0, next state WRITE.
- WRITE (exactly one cycle):
  - o_program_memory_write=1, o_instruction_write=word, o_address_write=addr.
  - Latency: 4th i_rx_done at cycle N -> write pulse at cycle N+1.
  - If word==HALT_WORD -> DONE.
  - Else if addr > ADDR_MAX-ADDR_INC -> ERROR (next word has no room).
  - Else addr += ADDR_INC -> RECV.
  - An i_rx_done arriving in the WRITE cycle is captured as byte 0 of the next word (byte_cnt=1, word={24'b0, i_rx_data}). If the next state is DONE or ERROR, that byte is dropped.
- DONE: o_load_done=1, o_busy=0, write enable 0; held until i_load_start (-> RECV, flag cleared) or rst.
- ERROR: o_error=1, o_busy=0; held until i_load_start or rst.
- i_load_start while in RECV/WRITE is ignored; there is no restart mid-load.
- o_program_memory_write is 0 in every cycle except WRITE.
- o_instruction_write/o_address_write hold their last written values outside WRITE.
- A partial word (fewer than 4 bytes) never causes a write.
- No timeout: RECV waits indefinitely.
- Address arithmetic is 8-bit unsigned; the overflow check prevents wrap to 0.

Test Plan:
- Reset: hold rst 2 cycles mid-RECV with 2 bytes received -> all outputs 0, state IDLE; a following i_rx_done produces no write.
- Single word + halt: start, bytes 12,34,56,78 then FF,FF,FF,FF -> write 0x12345678 @0x00, then write 0xFFFFFFFF @0x01 one cycle after the 8th strobe; o_load_done=1, o_busy=0.
- Back-to-back bytes: i_rx_done asserted on consecutive cycles for 12 bytes (3 words, last = halt) -> byte arriving in the WRITE cycle is not lost; writes at 0,1,2 with correct data.
- Overflow: ADDR_INC=1, stream 256 non-halt words -> 256 writes at 0x00..0xFF, then o_error=1 and no write to address 0x00 again; later bytes ignored.
- Restart: after DONE, pulse i_load_start -> o_load_done clears next cycle; new load writes from address 0. i_load_start pulsed mid-load -> ignored, address sequence continues.
- Partial word: 3 bytes then rst -> no write pulse ever observed.
